// File: rtl/csel_pipelined_subtractor.sv
// Pipelined N-bit subtractor (a - b - bin): one 4-bit carry-select slice per stage, global stall.
// Optional signed-overflow output is enabled by defining SUB_OVERFLOW_EN.
module csel_pipelined_subtractor #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf
);

    localparam int S = N / 4;

    // Handshake: a transfer happens on a rising edge where valid & ready are both high.
    // in_ready depends only on out_valid/out_ready, never on in_valid.
    logic advance;
    logic accept;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;
    assign accept   = in_valid & advance;

    genvar k;
    generate
        for (k = 0; k < S; k++) begin : g_stage
            localparam int W = N - 4 * k;

            logic           v_q;
            logic           v_d;
            logic           br_q;
            logic           br_d;
            logic [W-1:0]   a_q;
            logic [W-1:0]   a_d;
            logic [W-1:0]   b_q;
            logic [W-1:0]   b_d;
            logic [3:0]     d_b0;
            logic [3:0]     d_b1;
            logic [3:0]     d_sel;
            logic           bo_b0;
            logic           bo_b1;
            logic           bo_sel;
            logic [4*k+3:0] lo_out;

            // Both borrow-in outcomes are precomputed; the registered borrow only drives a mux.
            assign {bo_b0, d_b0} = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]};
            assign {bo_b1, d_b1} = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - 5'd1;
            assign d_sel  = br_q ? d_b1 : d_b0;
            assign bo_sel = br_q ? bo_b1 : bo_b0;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_q  <= 1'b0;
                    br_q <= 1'b0;
                    a_q  <= '0;
                    b_q  <= '0;
                end else if (advance) begin
                    v_q  <= v_d;
                    br_q <= br_d;
                    a_q  <= a_d;
                    b_q  <= b_d;
                end
            end

            if (k == 0) begin : g_head
                always_comb begin
                    v_d  = accept;
                    br_d = bin;
                    a_d  = a;
                    b_d  = b;
                end

                assign lo_out = d_sel;
            end else begin : g_body
                logic [4*k-1:0] lo_q;
                logic [4*k-1:0] lo_d;

                // Only the operand slices not yet consumed travel forward.
                always_comb begin
                    v_d  = g_stage[k-1].v_q;
                    br_d = g_stage[k-1].bo_sel;
                    a_d  = g_stage[k-1].a_q[W+3:4];
                    b_d  = g_stage[k-1].b_q[W+3:4];
                    lo_d = g_stage[k-1].lo_out;
                end

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        lo_q <= '0;
                    end else if (advance) begin
                        lo_q <= lo_d;
                    end
                end

                assign lo_out = {d_sel, lo_q};
            end
        end
    endgenerate

    // Last stage resolves the top slice combinationally from held registers, so a stall keeps it stable.
    assign out_valid = g_stage[S-1].v_q;
    assign diff      = g_stage[S-1].lo_out;
    assign bout      = g_stage[S-1].bo_sel;

`ifdef SUB_OVERFLOW_EN
    assign ovf = (g_stage[S-1].a_q[3] ^ g_stage[S-1].b_q[3]) & (diff[N-1] ^ g_stage[S-1].a_q[3]);
`else
    assign ovf = 1'b0;
`endif

endmodule
